// File: rtl/hub75_pkg.sv
// Shared constants, FSM encoding and pixel-word helpers for the HUB75 row shifter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default panel geometry, bit offsets of the six colour fields
// inside the 48-bit framebuffer word, the row-shift state encoding and a
// helper that extracts one bit plane from a pixel word.
package hub75_pkg;

  // Default panel geometry.
  localparam int COLS  = 128;
  localparam int ROWS  = 64;
  localparam int ROW_W = 6;

  // Bit planes per colour channel and width of the plane selector.
  localparam int PLANES = 8;
  localparam int BIT_W  = 3;

  // Pixel word layout {R0,G0,B0,R1,G1,B1}, 8 bits each, MSB first.
  localparam int PIX_W  = 48;
  localparam int OFF_R0 = 40;
  localparam int OFF_G0 = 32;
  localparam int OFF_B0 = 24;
  localparam int OFF_R1 = 16;
  localparam int OFF_G1 = 8;
  localparam int OFF_B1 = 0;

  // Row-shift sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LATENCY = 3'd2,
    ST_LOAD    = 3'd3,
    ST_SETUP   = 3'd4,
    ST_CLK_HI  = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // One bit plane of a pixel pair: upper half (0) and lower half (1).
  typedef struct packed {
    logic r0;
    logic g0;
    logic b0;
    logic r1;
    logic g1;
    logic b1;
  } colour_t;

  // Pick bit 'b' out of each 8-bit colour field of a pixel word.
  function automatic colour_t pick_plane(input logic [PIX_W-1:0] word,
                                         input logic [BIT_W-1:0] b);
    logic [PLANES-1:0] f_r0;
    logic [PLANES-1:0] f_g0;
    logic [PLANES-1:0] f_b0;
    logic [PLANES-1:0] f_r1;
    logic [PLANES-1:0] f_g1;
    logic [PLANES-1:0] f_b1;
    colour_t           c;
    f_r0 = word[OFF_R0 +: PLANES];
    f_g0 = word[OFF_G0 +: PLANES];
    f_b0 = word[OFF_B0 +: PLANES];
    f_r1 = word[OFF_R1 +: PLANES];
    f_g1 = word[OFF_G1 +: PLANES];
    f_b1 = word[OFF_B1 +: PLANES];
    c.r0 = f_r0[b];
    c.g0 = f_g0[b];
    c.b0 = f_b0[b];
    c.r1 = f_r1[b];
    c.g1 = f_g1[b];
    c.b1 = f_b1[b];
    return c;
  endfunction

endpackage

// File: rtl/hub75_fetchshift_counter.sv
// Column counter with synchronous clear and count enable.
// Latency: count_o updates on the rising edge after clr_i/en_i.
// Backpressure: none; clr_i has priority over en_i.
//
// Ports: clk_i (clock), rst_ni (async active-low reset), clr_i (sync clear),
// en_i (increment), count_o (current count).
module counter #(
  parameter int WIDTH = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hub75_fetchshift.sv
// Fetches one row/bit-plane from the framebuffer and shifts it into a HUB75 panel.
// Latency: busy rises 1 cycle after an accepted start; each pixel takes >= 5 cycles.
// Backpressure: display_clk paces the shift; starts are ignored while busy.
//
// Ports:
//   sys_clk, rst_n           sole clock, async active-low reset
//   display_clk              pacing strobe; advances SETUP and CLK_HI only
//   fetchshift_start         request, sampled only in IDLE with row_sel/bit_sel
//   fetchshift_busy          high from the cycle after accept until back in IDLE
//   rd_en, rd_addr, rd_data  framebuffer read; rd_data valid 1 cycle after rd_en
//   r0..b1, pix_clk          panel colour data and shift clock
module hub75_fetchshift #(
  parameter int COLS  = hub75_pkg::COLS,
  parameter int ROWS  = hub75_pkg::ROWS,
  parameter int ROW_W = hub75_pkg::ROW_W
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic                          display_clk,
  input  logic                          fetchshift_start,
  input  logic [ROW_W-1:0]              row_sel,
  input  logic [2:0]                    bit_sel,
  output logic                          fetchshift_busy,
  output logic                          rd_en,
  output logic [ROW_W+$clog2(COLS)-1:0] rd_addr,
  input  logic [47:0]                   rd_data,
  output logic                          r0,
  output logic                          g0,
  output logic                          b0,
  output logic                          r1,
  output logic                          g1,
  output logic                          b1,
  output logic                          pix_clk
);

  import hub75_pkg::*;

  localparam int COL_W  = $clog2(COLS);
  localparam int ADDR_W = ROW_W + COL_W;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  // Reject geometries the address packing cannot represent.
  if (ROW_W != $clog2(ROWS) || COLS < 2 || (COLS & (COLS - 1)) != 0) begin : g_bad_params
    $error("hub75_fetchshift: COLS must be a power of two >= 2 and ROW_W == clog2(ROWS)");
  end

  state_e              state_q;
  state_e              state_d;
  logic [ROW_W-1:0]    row_q;
  logic [BIT_W-1:0]    bit_q;
  logic [COL_W-1:0]    col;
  logic                col_clr;
  logic                col_en;
  logic                col_last;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   rd_addr_d;
  logic                rd_en_q;
  logic                pix_clk_q;
  logic                busy_q;
  colour_t             colour_q;

  // Column counter: parked at 0 while idle, advanced when CLK_HI hands off
  // to the next pixel. It never advances past the last column.
  assign col_last = (col == COL_LAST);
  assign col_clr  = (state_q == ST_IDLE);
  assign col_en   = (state_q == ST_CLK_HI) && display_clk && !col_last;

  counter #(
    .WIDTH (COL_W)
  ) u_col_cnt (
    .clk_i   (sys_clk),
    .rst_ni  (rst_n),
    .clr_i   (col_clr),
    .en_i    (col_en),
    .count_o (col)
  );

  // Next state. display_clk only matters in SETUP and CLK_HI, so a strobe
  // arriving elsewhere is simply dropped rather than remembered.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (fetchshift_start) state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_LATENCY;
      ST_LATENCY: state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_SETUP;
      ST_SETUP:   if (display_clk) state_d = ST_CLK_HI;
      ST_CLK_HI:  if (display_clk) state_d = col_last ? ST_DONE : ST_FETCH;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Address for the FETCH being entered. From IDLE the row register is not
  // loaded yet, so take row_sel directly; from CLK_HI the counter is about to
  // step, so present the following column.
  always_comb begin
    if (state_q == ST_IDLE) begin
      rd_addr_d = {row_sel, {COL_W{1'b0}}};
    end else begin
      rd_addr_d = {row_q, col + COL_W'(1)};
    end
  end

  // All outputs are registered from the next state so they line up exactly
  // with the state they belong to.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      bit_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      pix_clk_q <= 1'b0;
      busy_q    <= 1'b0;
      colour_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && fetchshift_start) begin
        row_q <= row_sel;
        bit_q <= bit_sel;
      end
      rd_en_q <= (state_d == ST_FETCH);
      if (state_d == ST_FETCH) begin
        rd_addr_q <= rd_addr_d;
      end
      // rd_data is only valid during LATENCY, i.e. on the edge into LOAD.
      if (state_d == ST_LOAD) begin
        colour_q <= pick_plane(rd_data, bit_q);
      end
      pix_clk_q <= (state_d == ST_CLK_HI);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign fetchshift_busy = busy_q;
  assign rd_en           = rd_en_q;
  assign rd_addr         = rd_addr_q;
  assign pix_clk         = pix_clk_q;
  assign r0              = colour_q.r0;
  assign g0              = colour_q.g0;
  assign b0              = colour_q.b0;
  assign r1              = colour_q.r1;
  assign g1              = colour_q.g1;
  assign b1              = colour_q.b1;

endmodule
